chacha_stream: RTL

- Parametrised ChaCha keystream generator. Round count and counter width are configurable; the block supports multi-block bursts with automatic block-counter increment.
- Output uses a valid/ready handshake, one 512-bit serialized keystream block per transfer.
- Sits between the key/nonce source (PRNG/TRNG seeding logic) and downstream EC/cipher consumers that need more than one block of keystream.

---
 rtl/chacha_stream.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/chacha_stream.sv
// ChaCha keystream generator: one round per cycle, feed-forward add, then a
// valid/ready output stage; multi-block bursts auto-increment the block counter.
module chacha_stream #(
   parameter int ROUNDS = 20,
   parameter int CTR_W  = 32
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                start,
   input  logic [255:0]        key,
   input  logic [127-CTR_W:0]  nonce,
   input  logic [CTR_W-1:0]    ctr_init,
   input  logic [15:0]         num_blocks,
   output logic                busy,
   output logic                stream_valid,
   input  logic                stream_ready,
   output logic [511:0]        stream,
   output logic                done,
   output logic                ctr_ovf
);

   localparam int NONCE_W = 128 - CTR_W;
   localparam int RC_W    = $clog2(ROUNDS + 1);

   typedef logic [15:0][31:0] blk_t;
   typedef enum logic [1:0] {IDLE, ROUND, ADD, OUT} state_t;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                       input logic [31:0] c_i, input logic [31:0] d_i);
      logic [31:0] a, b, c, d;
      a = a_i;
      b = b_i;
      c = c_i;
      d = d_i;
      a = a + b;  d = rotl(d ^ a, 16);
      c = c + d;  b = rotl(b ^ c, 12);
      a = a + b;  d = rotl(d ^ a, 8);
      c = c + d;  b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // Diagonal rounds shift rows b/c/d by 1/2/3 lanes; the 2-bit lane add wraps mod 4.
   function automatic blk_t chacha_round(input blk_t s, input logic diag);
      blk_t         r;
      logic [127:0] q;
      logic [1:0]   li;
      logic [3:0]   ia, ib, ic, id;
      r = s;
      for (int i = 0; i < 4; i++) begin
         li = 2'(i);
         ia = {2'b00, li};
         ib = {2'b01, li + {1'b0, diag}};
         ic = {2'b10, li + {diag, 1'b0}};
         id = {2'b11, li + {diag, diag}};
         q  = qr(s[ia], s[ib], s[ic], s[id]);
         r[ia] = q[127:96];
         r[ib] = q[95:64];
         r[ic] = q[63:32];
         r[id] = q[31:0];
      end
      return r;
   endfunction

   function automatic blk_t init_state(input logic [255:0] k, input logic [NONCE_W-1:0] n,
                                       input logic [CTR_W-1:0] c);
      blk_t s;
      s    = '0;
      s[0] = 32'h61707865;
      s[1] = 32'h3320646e;
      s[2] = 32'h79622d32;
      s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = k[255 - 32*i -: 32];
      for (int j = 0; j < CTR_W / 32; j++) s[12 + j] = c[32*j +: 32];
      for (int j = 0; j < NONCE_W / 32; j++) s[15 - j] = n[32*j +: 32];
      return s;
   endfunction

   function automatic blk_t add_blk(input blk_t a, input blk_t b);
      blk_t r;
      for (int i = 0; i < 16; i++) r[i] = a[i] + b[i];
      return r;
   endfunction

   function automatic logic [511:0] serialize(input blk_t s);
      logic [511:0] o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[32*(15-i) +: 32] = {s[i][7:0], s[i][15:8], s[i][23:16], s[i][31:24]};
      return o;
   endfunction

   state_t             state_q, state_d;
   blk_t               work_q, work_d, orig;
   logic [255:0]       key_q, key_d;
   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d, ctr_inc;
   logic [15:0]        rem_q, rem_d;
   logic [RC_W-1:0]    rc_q, rc_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   // The original state is rebuilt from the latched inputs and the live counter.
   assign orig    = init_state(key_q, nonce_q, ctr_q);
   assign ctr_inc = ctr_q + CTR_W'(1);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         key_q   <= '0;
         nonce_q <= '0;
         ctr_q   <= '0;
         rem_q   <= '0;
         rc_q    <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         key_q   <= key_d;
         nonce_q <= nonce_d;
         ctr_q   <= ctr_d;
         rem_q   <= rem_d;
         rc_q    <= rc_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      key_d   = key_q;
      nonce_d = nonce_q;
      ctr_d   = ctr_q;
      rem_d   = rem_q;
      rc_d    = rc_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key;
               nonce_d = nonce;
               ctr_d   = ctr_init;
               rem_d   = num_blocks;
               rc_d    = '0;
               ovf_d   = 1'b0;
               work_d  = init_state(key, nonce, ctr_init);
               state_d = ROUND;
            end
         end
         ROUND: begin
            work_d = chacha_round(work_q, rc_q[0]);
            rc_d   = rc_q + RC_W'(1);
            if (rc_q == RC_W'(ROUNDS - 1)) state_d = ADD;
         end
         ADD: begin
            work_d  = add_blk(work_q, orig);
            state_d = OUT;
         end
         OUT: begin
            if (stream_ready) begin
               // A zero block count means free-running: never decrement, never stop.
               if (rem_q == 16'd0 || rem_q > 16'd1) begin
                  ctr_d = ctr_inc;
                  if (ctr_inc == '0) ovf_d = 1'b1;
                  if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
                  work_d  = init_state(key_q, nonce_q, ctr_inc);
                  rc_d    = '0;
                  state_d = ROUND;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy         = (state_q != IDLE);
   assign stream_valid = (state_q == OUT);
   assign stream       = stream_valid ? serialize(work_q) : '0;
   assign done         = done_q;
   assign ctr_ovf      = ovf_q;

endmodule
